// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM.
// Misaligned commands are rejected without touching the RAM; stalled accesses abort after TIMEOUT cycles.
module ram_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [1:0]  m0_hb_i,
  input  logic        m0_uload_i,
  output logic        m0_gnt_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [1:0]  m1_hb_i,
  input  logic        m1_uload_i,
  output logic        m1_gnt_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,

  output logic        ram_ce_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [1:0]  ram_hb_o,
  output logic        ram_uload_o,
  input  logic        ram_gnt_i,
  input  logic [31:0] ram_rdata_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    ACCESS  = 3'b010,
    RELEASE = 3'b100
  } state_t;

  state_t      state;
  logic        owner;
  logic        last_served;
  logic [7:0]  count;
  logic [1:0]  gnt_q;
  logic [1:0]  err_q;
  logic [31:0] rdata0;
  logic [31:0] rdata1;

  logic        pick;
  logic [31:0] pick_addr;
  logic [1:0]  pick_hb;
  logic        pick_bad;
  logic        own_we;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [1:0]  own_hb;
  logic        own_uload;
  logic        in_access;

  // On a tie the master that was not served last wins; a lone requester always wins.
  assign pick      = (m0_req_i && m1_req_i) ? ~last_served : m1_req_i;
  assign pick_addr = pick ? m1_addr_i : m0_addr_i;
  assign pick_hb   = pick ? m1_hb_i   : m0_hb_i;
  assign pick_bad  = (pick_hb == 2'b11) ||
                     ((pick_hb == 2'b10) && (pick_addr[1:0] != 2'b00)) ||
                     ((pick_hb == 2'b01) && pick_addr[0]);

  assign own_we    = owner ? m1_we_i    : m0_we_i;
  assign own_addr  = owner ? m1_addr_i  : m0_addr_i;
  assign own_wdata = owner ? m1_wdata_i : m0_wdata_i;
  assign own_hb    = owner ? m1_hb_i    : m0_hb_i;
  assign own_uload = owner ? m1_uload_i : m0_uload_i;

  // RAM side is driven only while the state register says ACCESS, so reset drops it at once.
  assign in_access   = (state == ACCESS);
  assign ram_req_o   = in_access;
  assign ram_ce_o    = in_access;
  assign ram_we_o    = in_access ? own_we    : 1'b0;
  assign ram_addr_o  = in_access ? own_addr  : 32'h0;
  assign ram_wdata_o = in_access ? own_wdata : 32'h0;
  assign ram_hb_o    = in_access ? own_hb    : 2'b00;
  assign ram_uload_o = in_access ? own_uload : 1'b0;

  assign m0_gnt_o   = gnt_q[0];
  assign m1_gnt_o   = gnt_q[1];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m0_rdata_o = rdata0;
  assign m1_rdata_o = rdata1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      count       <= 8'd0;
      gnt_q       <= 2'b00;
      err_q       <= 2'b00;
      rdata0      <= 32'h0;
      rdata1      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            owner <= pick;
            if (pick_bad) begin
              state <= RELEASE;
              gnt_q <= {pick, ~pick};
              err_q <= {pick, ~pick};
            end else begin
              state <= ACCESS;
              count <= 8'd0;
            end
          end
        end
        ACCESS: begin
          if (ram_gnt_i) begin
            if (!own_we) begin
              if (owner) rdata1 <= ram_rdata_i;
              else       rdata0 <= ram_rdata_i;
            end
            state <= RELEASE;
            gnt_q <= {owner, ~owner};
            err_q <= 2'b00;
          end else if (count == 8'(TIMEOUT - 1)) begin
            state <= RELEASE;
            gnt_q <= {owner, ~owner};
            err_q <= {owner, ~owner};
          end else begin
            count <= count + 8'd1;
          end
        end
        RELEASE: begin
          gnt_q       <= 2'b00;
          err_q       <= 2'b00;
          last_served <= owner;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: RAM model with byte/half lanes, per-master scoreboards,
// a vector table for single transactions and hand sequences for timeout, reset and round-robin.
module tb_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req, m0_we, m0_uload, m1_req, m1_we, m1_uload;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_hb, m1_hb;
  logic        m0_gnt_o, m0_err_o, m1_gnt_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        ram_ce_o, ram_req_o, ram_we_o, ram_uload_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [1:0]  ram_hb_o;
  logic        ram_gnt;
  logic [31:0] ram_rdata;

  ram_arbiter #(.TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_hb_i(m0_hb), .m0_uload_i(m0_uload), .m0_gnt_o(m0_gnt_o), .m0_err_o(m0_err_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_hb_i(m1_hb), .m1_uload_i(m1_uload), .m1_gnt_o(m1_gnt_o), .m1_err_o(m1_err_o),
    .m1_rdata_o(m1_rdata_o),
    .ram_ce_o(ram_ce_o), .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_hb_o(ram_hb_o), .ram_uload_o(ram_uload_o),
    .ram_gnt_i(ram_gnt), .ram_rdata_i(ram_rdata)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  hb;
    logic        uload;
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          ramc;
  } vec_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_rd[2];
  int          tests = 0;
  int          errors = 0;
  int          cyc = 0;
  int          req_cycles = 0;
  int          ce_cycles = 0;
  logic        gnt_en;
  logic [7:0]  req_cnt;
  logic [31:0] mem[0:63];
  vec_t        vecs[11];

  always @(posedge clk_i) cyc <= cyc + 1;

  // RAM model: grants in the third cycle of a request, optionally never.
  assign ram_gnt = ram_req_o && gnt_en && (req_cnt == 8'd2);

  always @(posedge clk_i) begin
    if (ram_req_o && !ram_gnt) req_cnt <= req_cnt + 8'd1;
    else                       req_cnt <= 8'd0;
    if (ram_gnt && ram_we_o) begin
      case (ram_hb_o)
        2'b01:   if (ram_addr_o[1]) mem[ram_addr_o[7:2]][31:16] <= ram_wdata_o[15:0];
                 else               mem[ram_addr_o[7:2]][15:0]  <= ram_wdata_o[15:0];
        2'b00:   mem[ram_addr_o[7:2]][ram_addr_o[1:0]*8 +: 8] <= ram_wdata_o[7:0];
        default: mem[ram_addr_o[7:2]] <= ram_wdata_o;
      endcase
    end
  end

  always_comb begin
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = mem[ram_addr_o[7:2]];
    h = ram_addr_o[1] ? w[31:16] : w[15:0];
    b = w[ram_addr_o[1:0]*8 +: 8];
    ram_rdata = 32'h0;
    if (ram_gnt) begin
      case (ram_hb_o)
        2'b01:   ram_rdata = ram_uload_o ? {16'h0, h} : {{16{h[15]}}, h};
        2'b00:   ram_rdata = ram_uload_o ? {24'h0, b} : {{24{b[7]}}, b};
        default: ram_rdata = w;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: RAM bus idle outside ACCESS, qualified errors, and scoreboard pops on each grant.
  always @(negedge clk_i) begin
    exp_t e;
    if (ram_req_o) req_cycles++;
    if (ram_ce_o) ce_cycles++;
    if (!ram_req_o)
      check_output("ram_idle_cmd", 32'(ram_ce_o | ram_we_o | (|ram_addr_o) | (|ram_wdata_o) |
                                        (|ram_hb_o) | ram_uload_o), 32'h0);
    check_output("gnt_onehot", 32'(m0_gnt_o & m1_gnt_o), 32'h0);
    check_output("err_qual0", 32'(m0_err_o & ~m0_gnt_o), 32'h0);
    check_output("err_qual1", 32'(m1_err_o & ~m1_gnt_o), 32'h0);
    if (m0_gnt_o) begin
      if (q0.size() == 0) check_output("unexpected_gnt0", 32'h1, 32'h0);
      else begin
        e = q0.pop_front();
        check_output("err0", 32'(m0_err_o), 32'(e.err));
        check_output("rdata0", m0_rdata_o, e.rdata);
        check_output("gnt0_cycle", cyc, e.due);
      end
    end
    if (m1_gnt_o) begin
      if (q1.size() == 0) check_output("unexpected_gnt1", 32'h1, 32'h0);
      else begin
        e = q1.pop_front();
        check_output("err1", 32'(m1_err_o), 32'(e.err));
        check_output("rdata1", m1_rdata_o, e.rdata);
        check_output("gnt1_cycle", cyc, e.due);
      end
    end
  end

  // Issue one command for master m, push its expectation, wait for the grant and drop the request.
  task automatic apply_stimulus(input int m, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] hb, input logic uload,
                                input logic exp_err, input logic [31:0] exp_rd,
                                input int lat, input int ramc);
    exp_t e;
    int   base_req, base_ce;
    logic seen;
    e.err   = exp_err;
    if (!we && !exp_err) last_rd[m] = exp_rd;
    e.rdata = last_rd[m];
    e.due   = cyc + lat;
    base_req = req_cycles;
    base_ce  = ce_cycles;
    if (m == 0) begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_hb = hb; m0_uload = uload; m0_req = 1'b1;
      q0.push_back(e);
    end else begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_hb = hb; m1_uload = uload; m1_req = 1'b1;
      q1.push_back(e);
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_i);
      seen = (m == 0) ? m0_gnt_o : m1_gnt_o;
    end
    if (!seen) check_output("gnt_wait_expired", 32'h0, 32'h1);
    @(posedge clk_i);
    #1;
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
    if (ramc >= 0) begin
      check_output("ram_req_cycles", req_cycles - base_req, ramc);
      check_output("ram_ce_cycles", ce_cycles - base_ce, ramc);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hCACACACA;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    gnt_en = 1'b1;
    rst_ni = 1'b0;
    {m0_req, m0_we, m0_uload, m1_req, m1_we, m1_uload} = '0;
    {m0_addr, m0_wdata, m1_addr, m1_wdata, m0_hb, m1_hb} = '0;

    //           m  we    addr          wdata         hb     ul    err   rd             lat ramc
    vecs[0]  = '{0, 1'b0, 32'h10, 32'h0,      2'b10, 1'b0, 1'b0, 32'hCACACACA, 4,  3};
    vecs[1]  = '{1, 1'b1, 32'h02, 32'h1234,   2'b10, 1'b0, 1'b1, 32'h0,        1,  0};
    vecs[2]  = '{0, 1'b1, 32'h21, 32'hAB,     2'b00, 1'b0, 1'b0, 32'h0,        4,  3};
    vecs[3]  = '{0, 1'b0, 32'h21, 32'h0,      2'b00, 1'b1, 1'b0, 32'h000000AB, 4,  3};
    vecs[4]  = '{1, 1'b1, 32'h22, 32'hBEEF,   2'b01, 1'b0, 1'b0, 32'h0,        4,  3};
    vecs[5]  = '{1, 1'b0, 32'h22, 32'h0,      2'b01, 1'b0, 1'b0, 32'hFFFFBEEF, 4,  3};
    vecs[6]  = '{1, 1'b0, 32'h22, 32'h0,      2'b01, 1'b1, 1'b0, 32'h0000BEEF, 4,  3};
    vecs[7]  = '{0, 1'b0, 32'h13, 32'h0,      2'b01, 1'b1, 1'b1, 32'h0,        1,  0};
    vecs[8]  = '{0, 1'b1, 32'h10, 32'h55,     2'b11, 1'b0, 1'b1, 32'h0,        1,  0};
    vecs[9]  = '{1, 1'b0, 32'h20, 32'h0,      2'b10, 1'b0, 1'b0, 32'hBEEFAB00, 4,  3};
    vecs[10] = '{0, 1'b0, 32'h12, 32'h0,      2'b10, 1'b0, 1'b1, 32'h0,        1,  0};

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_output("rst_ram_req", 32'(ram_req_o), 32'h0);
    check_output("rst_ram_ce", 32'(ram_ce_o), 32'h0);
    check_output("rst_gnt", 32'({m0_gnt_o, m1_gnt_o, m0_err_o, m1_err_o}), 32'h0);
    check_output("rst_rdata0", m0_rdata_o, 32'h0);
    check_output("rst_rdata1", m1_rdata_o, 32'h0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 11; i++)
      apply_stimulus(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hb,
                     vecs[i].uload, vecs[i].err, vecs[i].rd, vecs[i].lat, vecs[i].ramc);

    // RAM that never answers: abort after 16 ACCESS cycles, read data untouched.
    gnt_en = 1'b0;
    apply_stimulus(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b1, 32'h0, 17, 16);
    gnt_en = 1'b1;

    // Reset in the second ACCESS cycle kills the RAM request with no grant.
    m0_we = 1'b0; m0_addr = 32'h10; m0_hb = 2'b10; m0_uload = 1'b0; m0_req = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check_output("pre_rst_ram_req", 32'(ram_req_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("mid_rst_ram_req", 32'(ram_req_o), 32'h0);
    check_output("mid_rst_ram_ce", 32'(ram_ce_o), 32'h0);
    check_output("mid_rst_rdata0", m0_rdata_o, 32'h0);
    check_output("mid_rst_rdata1", m1_rdata_o, 32'h0);
    m0_req = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    @(posedge clk_i); #1;
    apply_stimulus(1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'hCACACACA, 4, 3);

    // Both masters keep requesting: m0, m1, m0, m1 with grants five cycles apart.
    fork
      begin
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'hCACACACA, 4, -1);
        apply_stimulus(0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 32'hBEEFAB00, 9, -1);
      end
      begin
        apply_stimulus(1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 32'hBEEFAB00, 9, -1);
        apply_stimulus(1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 1'b0, 32'hFFFFFFAB, 9, -1);
      end
    join

    repeat (3) @(posedge clk_i);
    check_output("q0_drained", q0.size(), 32'h0);
    check_output("q1_drained", q1.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of ACCESS cycles without ram_gnt_i before the transaction aborts (range 4..255).
REQ-002 SHALL have port clk_i  input  1  system clock, rising-edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mK_req_i (K=0,1)  input  1  master K request, held high until mK_gnt_o.
REQ-005 SHALL have ports mK_we_i 1, mK_addr_i 32, mK_wdata_i 32, mK_hb_i 2, mK_uload_i 1  input  master K command; stable while mK_req_i is high.
REQ-006 SHALL have port mK_gnt_o  output  1  one-cycle completion pulse to master K.
REQ-007 SHALL have port mK_err_o  output  1  error qualifier, valid only with mK_gnt_o.
REQ-008 SHALL have port mK_rdata_o  output  32  registered read data for master K, valid from mK_gnt_o until the next read completion for K.
REQ-009 SHALL have ports ram_ce_o 1, ram_req_o 1  output  RAM select/request.
REQ-010 SHALL have ports ram_we_o 1, ram_addr_o 32, ram_wdata_o 32, ram_hb_o 2, ram_uload_o 1  output  RAM command.
REQ-011 SHALL have ports ram_gnt_i 1, ram_rdata_i 32  input  RAM grant and read data (valid during the ram_gnt_i cycle).

Function
REQ-012 SHALL implement a one-hot FSM: IDLE, ACCESS, RELEASE.
REQ-013 IDLE: with no mK_req_i high, remain in IDLE; otherwise select the owner and latch it.
REQ-014 Arbitration SHALL be round-robin: with one requester, grant it; with both, grant the master not served last (last_served pointer).
REQ-015 In IDLE, a misaligned owner request (hb=10 with addr[1:0]!=0, or hb=01 with addr[0]=1) or hb=11 SHALL go directly to RELEASE with err; RAM is not accessed.
REQ-016 Otherwise IDLE SHALL go to ACCESS.
REQ-017 ram_req_o and ram_ce_o SHALL be 1 exactly while in ACCESS.
REQ-018 ram_we_o/addr/wdata/hb/uload SHALL be muxed from the latched owner's live inputs; 0 when not in ACCESS.
REQ-019 ACCESS: ram_gnt_i=1 SHALL capture ram_rdata_i into the owner's rdata register if the command is a read, and move to RELEASE with err=0.
REQ-020 ACCESS: a cycle counter SHALL clear on entry and increment each cycle; reaching TIMEOUT without ram_gnt_i SHALL move to RELEASE with err=1, rdata unchanged.
REQ-021 RELEASE: assert mK_gnt_o=1 for the owner (mK_err_o per REQ-015/019/020); update last_served=owner; go to IDLE next cycle.
REQ-022 Requests SHALL NOT be sampled in ACCESS or RELEASE; the non-owner waits.
REQ-023 Nominal latency: request seen in IDLE at cycle 0 -> ACCESS cycle 1 -> RAM grant cycle 3 -> mK_gnt_o in cycle 4.
REQ-024 ram_req_o SHALL be 0 in RELEASE so the RAM returns to idle before the next access (back-to-back accesses: 5-cycle period).
REQ-025 Masters SHALL deassert mK_req_i on the edge ending the mK_gnt_o cycle; the arbiter does not check this.

Reset
REQ-026 rst_ni low SHALL force IDLE, last_served=1 (master 0 wins the first tie), counter=0, all outputs 0, and both rdata registers to 0.
REQ-027 Reset mid-ACCESS SHALL drop ram_req_o immediately (asynchronous) with no gnt_o issued.

Verification
REQ-028 m0 read word addr 0x10 (RAM holds 0xCACACACA) -> m0_gnt_o in cycle 4, m0_err_o=0, m0_rdata_o=0xCACACACA.
REQ-029 m0 and m1 request in the same cycle, both held, repeated -> grant order m0, m1, m0, m1; each gnt 5 cycles apart.
REQ-030 m1 write hb=10 addr 0x02 -> m1_gnt_o with m1_err_o=1 in cycle 1; ram_req_o never asserted.
REQ-031 RAM model never grants, TIMEOUT=16 -> m0_gnt_o with m0_err_o=1 after 16 ACCESS cycles; m0_rdata_o unchanged.
REQ-032 rst_ni low in ACCESS cycle 2 -> ram_req_o=0 immediately, no gnt; after release, a new m1 request completes normally.
REQ-033 m0 byte write 0xAB to addr 0x21, then a byte read at 0x21 -> m0_rdata_o=0x000000AB.
